// File: rtl/cfs_apb_slv_pkg.sv
// Shared types and constants for the cfs_apb register completer.
package cfs_apb_slv_pkg;

  localparam int CFS_APB_MAX_ADDR_WIDTH = 32;
  localparam int CFS_APB_MAX_DATA_WIDTH = 32;
  localparam int REG_STRIDE             = 4;
  localparam logic [31:0] CFS_APB_ID_DEFAULT = 32'hCF5A_0001;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO
  } err_cause_t;

endpackage

// File: rtl/cfs_apb_slv_regfile.sv
// Read/write word storage for registers 1..NUM_REGS-1; register 0 is the ID word and lives in the top.
module cfs_apb_slv_regfile #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic                               pclk,
  input  logic                               preset_n,
  input  logic                               we,
  input  logic [IDX_W-1:0]                   idx,
  input  logic [DATA_WIDTH-1:0]              wdata,
  output logic [DATA_WIDTH-1:0]              rdata,
  output logic [(NUM_REGS-1)*DATA_WIDTH-1:0] regs_flat
);

  logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && idx != '0 && int'(idx) < NUM_REGS) begin
      mem[idx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (idx != '0 && int'(idx) < NUM_REGS) rdata = mem[idx];
  end

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[(i-1)*DATA_WIDTH +: DATA_WIDTH] = mem[i];
  end

endmodule

// File: rtl/cfs_apb_slave_regs.sv
// APB completer: read-only ID word plus RW register bank, programmable wait states,
// PSLVERR on illegal accesses and a one-cycle pulse on bus protocol violations.
module cfs_apb_slave_regs
  import cfs_apb_slv_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = CFS_APB_ID_DEFAULT
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           pwrite,
  input  logic                           psel,
  input  logic                           penable,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic                           proto_err_o
);

  // state  | meaning
  // IDLE   | no transfer in flight; SETUP phase decoded here
  // ACCESS | transfer latched; cnt counts remaining wait states

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(REG_STRIDE * NUM_REGS);
  localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [DATA_WIDTH-1:0] ID_WORD    = DATA_WIDTH'(ID_VALUE);

  state_t                           state;
  logic [3:0]                       cnt;
  logic [ADDR_WIDTH-1:0]            lat_addr;
  logic                             lat_write;
  logic [DATA_WIDTH-1:0]            lat_wdata;
  err_cause_t                       err_cause;
  logic [IDX_W-1:0]                 idx;
  logic                             completing;
  logic                             reg_we;
  logic [DATA_WIDTH-1:0]            rf_rdata;
  logic [(NUM_REGS-1)*DATA_WIDTH-1:0] rw_regs;

  assign idx = lat_addr[IDX_W+1:2];

  always_comb begin
    err_cause = ERR_NONE;
    if (lat_addr[1:0] != 2'b00)                err_cause = ERR_ALIGN;
    else if ({1'b0, lat_addr} >= ADDR_LIMIT)   err_cause = ERR_RANGE;
    else if (lat_write && idx == '0)           err_cause = ERR_RO;
  end

  assign completing = (state == ACCESS) && psel && penable && (cnt == '0);
  assign pready     = completing;
  assign pslverr    = completing && (err_cause != ERR_NONE);
  assign reg_we     = completing && lat_write && (err_cause == ERR_NONE);

  always_comb begin
    prdata = '0;
    if (completing && !lat_write && err_cause == ERR_NONE)
      prdata = (idx == '0) ? ID_WORD : rf_rdata;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_write   <= 1'b0;
      lat_wdata   <= '0;
      proto_err_o <= 1'b0;
    end else begin
      proto_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            lat_addr  <= paddr;
            lat_write <= pwrite;
            lat_wdata <= pwdata;
            cnt       <= WAIT_LOAD;
            state     <= ACCESS;
          end else if (psel && penable) begin
            proto_err_o <= 1'b1;
          end
        end
        ACCESS: begin
          if (!psel) begin
            proto_err_o <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else if (!penable) begin
            // a fresh SETUP while still in ACCESS restarts the transfer
            lat_addr    <= paddr;
            lat_write   <= pwrite;
            lat_wdata   <= pwdata;
            cnt         <= WAIT_LOAD;
            proto_err_o <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cfs_apb_slv_regfile #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (reg_we),
    .idx      (idx),
    .wdata    (lat_wdata),
    .rdata    (rf_rdata),
    .regs_flat(rw_regs)
  );

  assign regs_o = {rw_regs, ID_WORD};

endmodule

// File: tb/tb_cfs_apb_slave_regs.sv
// Bench for cfs_apb_slave_regs: instance 0 has no wait states, instance 1 has three.
module tb_cfs_apb_slave_regs;

  localparam logic [31:0] ID = 32'hCF5A_0001;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic [15:0] paddr   [2];
  logic        pwrite  [2];
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [255:0] regs_o [2];
  logic        proto_err [2];

  logic [31:0] mem [2][8];
  logic        exp_ready [2];
  logic        exp_err   [2];
  logic [31:0] exp_rdata [2];
  logic        exp_perr  [2];
  logic        perr_pend [2];

  int checks = 0;
  int fails  = 0;

  always #5 pclk = ~pclk;

  cfs_apb_slave_regs #(.WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr[0]), .pwrite(pwrite[0]),
    .psel(psel[0]), .penable(penable[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .regs_o(regs_o[0]), .proto_err_o(proto_err[0])
  );

  cfs_apb_slave_regs #(.WAIT_CYCLES(3)) u_dut3 (
    .pclk(pclk), .preset_n(preset_n), .paddr(paddr[1]), .pwrite(pwrite[1]),
    .psel(psel[1]), .penable(penable[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .regs_o(regs_o[1]), .proto_err_o(proto_err[1])
  );

  function automatic bit model_err(input bit wr, input logic [15:0] a);
    return (a[1:0] != 2'b00) || (a >= 16'd32) || (wr && a == 16'd0);
  endfunction

  function automatic logic [255:0] model_regs(input int d);
    logic [255:0] v;
    for (int r = 0; r < 8; r++) v[r*32 +: 32] = mem[d][r];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mem[d][0] = ID;
      for (int r = 1; r < 8; r++) mem[d][r] = 32'h0;
      exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = 32'h0;
      exp_perr[d] = 1'b0; perr_pend[d] = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // per-cycle comparison of both instances against the transaction model
  always @(negedge pclk) begin
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (pready[i] !== exp_ready[i] || pslverr[i] !== exp_err[i] ||
          prdata[i] !== exp_rdata[i] || proto_err[i] !== exp_perr[i] ||
          regs_o[i] !== model_regs(i)) begin
        fails++;
        $display("FAIL cycle_cmp dut%0d t=%0t actual rdy=%b err=%b rd=%h perr=%b regs=%h required rdy=%b err=%b rd=%h perr=%b regs=%h",
                 i, $time, pready[i], pslverr[i], prdata[i], proto_err[i], regs_o[i],
                 exp_ready[i], exp_err[i], exp_rdata[i], exp_perr[i], model_regs(i));
      end
    end
  end

  task automatic cyc();
    @(posedge pclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_perr[i]  = perr_pend[i];
      perr_pend[i] = 1'b0;
    end
  endtask

  task automatic bus_idle(input int d);
    psel[d] = 1'b0; penable[d] = 1'b0;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = 32'h0;
  endtask

  // Full transfer starting with SETUP in the current cycle; bus inputs are scrambled during
  // ACCESS so only the latched values may matter. Returns just after the completing edge.
  task automatic xfer(input int d, input bit wr, input logic [15:0] a, input logic [31:0] wd,
                      input bit viol, output logic [31:0] rd, output bit er, output int lat);
    int w = (d == 0) ? 0 : 3;
    bit e = model_err(wr, a);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = 32'h0;
    perr_pend[d] = viol;
    rd = 32'h0; er = 1'b0; lat = 0;
    for (int k = 0; k <= w; k++) begin
      cyc();
      penable[d] = 1'b1; paddr[d] = a ^ 16'h0014; pwrite[d] = ~wr; pwdata[d] = ~wd;
      exp_ready[d] = (k == w);
      exp_err[d]   = (k == w) && e;
      exp_rdata[d] = (k == w && !wr && !e) ? mem[d][a[4:2]] : 32'h0;
      @(negedge pclk);
      if (pready[d] && lat == 0) begin
        lat = k + 1; rd = prdata[d]; er = pslverr[d];
      end
    end
    cyc();
    if (wr && !e) mem[d][a[4:2]] = wd;
    bus_idle(d);
  endtask

  initial begin
    logic [31:0] rd;
    bit er;
    int lat;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      paddr[d] = 16'h0; pwrite[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwdata[d] = 32'h0;
    end

    @(negedge pclk);
    chk("rst_pready", {pready[0], pready[1]}, 64'h0);
    chk("rst_pslverr", {pslverr[0], pslverr[1]}, 64'h0);
    chk("rst_prdata", {prdata[0], prdata[1]}, 64'h0);
    chk("rst_proto_err", {proto_err[0], proto_err[1]}, 64'h0);
    chk("rst_regs_low", regs_o[0][63:0], {32'h0, ID});
    cyc(); cyc();
    preset_n = 1'b1;
    cyc();

    // zero wait states: write then read reg 1
    xfer(0, 1'b1, 16'h0004, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
    chk("w0_wr_lat", 64'(lat), 64'd1);
    chk("w0_wr_err", 64'(er), 64'd0);
    cyc();
    xfer(0, 1'b0, 16'h0004, 32'h0, 1'b0, rd, er, lat);
    chk("w0_rd_data", 64'(rd), 64'hDEAD_BEEF);
    chk("w0_rd_lat", 64'(lat), 64'd1);

    // three wait states: ID read, illegal ID write
    cyc();
    xfer(1, 1'b0, 16'h0000, 32'h0, 1'b0, rd, er, lat);
    chk("w3_id_lat", 64'(lat), 64'd4);
    chk("w3_id_data", 64'(rd), 64'hCF5A_0001);
    cyc();
    xfer(1, 1'b1, 16'h0000, 32'h1111_2222, 1'b0, rd, er, lat);
    chk("w3_id_wr_err", 64'(er), 64'd1);
    cyc();
    xfer(1, 1'b0, 16'h0000, 32'h0, 1'b0, rd, er, lat);
    chk("w3_id_unchanged", 64'(rd), 64'hCF5A_0001);

    // out-of-range read and misaligned write
    cyc();
    xfer(0, 1'b0, 16'h0020, 32'h0, 1'b0, rd, er, lat);
    chk("range_err", 64'(er), 64'd1);
    chk("range_rdata", 64'(rd), 64'h0);
    cyc();
    xfer(0, 1'b1, 16'h0006, 32'h0000_0055, 1'b0, rd, er, lat);
    chk("align_err", 64'(er), 64'd1);
    chk("align_regs", regs_o[0][95:32], {32'h0, 32'hDEAD_BEEF});

    // back-to-back write then read of reg 7
    cyc();
    xfer(0, 1'b1, 16'h001C, 32'h0000_0005, 1'b0, rd, er, lat);
    xfer(0, 1'b0, 16'h001C, 32'h0, 1'b0, rd, er, lat);
    chk("b2b_rdata", 64'(rd), 64'h5);

    // psel dropped during wait states of a write to reg 2
    cyc();
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 16'h0008; pwdata[1] = 32'hFF;
    cyc();
    penable[1] = 1'b1;
    cyc();
    psel[1] = 1'b0; penable[1] = 1'b0; perr_pend[1] = 1'b1;
    cyc();
    @(negedge pclk);
    chk("abort_perr", 64'(proto_err[1]), 64'd1);
    chk("abort_reg2", regs_o[1][95:64], 64'h0);
    cyc();

    // ACCESS without SETUP
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 16'h0004; pwdata[1] = 32'hAAAA;
    perr_pend[1] = 1'b1;
    @(negedge pclk);
    chk("nosetup_pready", 64'(pready[1]), 64'd0);
    cyc();
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge pclk);
    chk("nosetup_perr", 64'(proto_err[1]), 64'd1);
    cyc();

    // SETUP during ACCESS restarts the transfer with the new address
    xfer(1, 1'b1, 16'h0010, 32'h0000_0077, 1'b0, rd, er, lat);
    cyc();
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 16'h0004;
    cyc();
    penable[1] = 1'b1;
    cyc();
    xfer(1, 1'b0, 16'h0010, 32'h0, 1'b1, rd, er, lat);
    chk("relatch_data", 64'(rd), 64'h77);
    chk("relatch_lat", 64'(lat), 64'd4);

    // reset asserted in the completing cycle of a write to reg 3
    cyc();
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 16'h000C; pwdata[0] = 32'h1234;
    cyc();
    penable[0] = 1'b1;
    #1;
    model_reset();
    preset_n = 1'b0;
    @(negedge pclk);
    chk("rstmid_pready", 64'(pready[0]), 64'd0);
    chk("rstmid_reg3", regs_o[0][127:96], 64'h0);
    cyc();
    bus_idle(0);
    cyc();
    preset_n = 1'b1;
    cyc();
    xfer(0, 1'b0, 16'h000C, 32'h0, 1'b0, rd, er, lat);
    chk("post_rst_reg3", 64'(rd), 64'h0);
    xfer(0, 1'b0, 16'h0004, 32'h0, 1'b0, rd, er, lat);
    chk("post_rst_reg1", 64'(rd), 64'h0);

    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
